// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the host/conv masters, the arbiter and the scratch memory.
// The bidirectional data_bus stays a plain port on the arbiter.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic              h_req;
    logic              h_gnt;
    logic              h_sel;
    logic              h_w_en;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic [DATA_W-1:0] h_rdata;
    logic              c_req;
    logic              c_gnt;
    logic              c_sel;
    logic              c_w_en;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              mem_sel;
    logic              mem_w_en;
    logic [ADDR_W-1:0] address_bus;
    logic [1:0]        owner;

    // Arbiter side
    modport slave (
        input  h_req, h_sel, h_w_en, h_addr, h_wdata,
        input  c_req, c_sel, c_w_en, c_addr, c_wdata,
        output h_gnt, h_rdata, c_gnt, c_rdata,
        output mem_sel, mem_w_en, address_bus, owner
    );

    // Master/memory side
    modport master (
        output h_req, h_sel, h_w_en, h_addr, h_wdata,
        output c_req, c_sel, c_w_en, c_addr, c_wdata,
        input  h_gnt, h_rdata, c_gnt, c_rdata,
        input  mem_sel, mem_w_en, address_bus, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (host/conv) arbiter for the scratch memory bus with a one-cycle turnaround.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of favouring the host.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus_if,
    inout  wire  [DATA_W-1:0] data_bus
);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_SAT =
        (MAX_BURST != 0) ? CNT_W'(MAX_BURST - 1) : {CNT_W{1'b1}};
    localparam bit BURST_LIM = (MAX_BURST != 0);

    // State encoding doubles as the debug owner code
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_GNT_H = 2'b01;
    localparam logic [1:0] S_GNT_C = 2'b10;
    localparam logic [1:0] S_TURN  = 2'b11;

    localparam logic OWN_H = 1'b0;
    localparam logic OWN_C = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic              last_owner_q, last_owner_d;
    logic              preempt_q, preempt_d;
    logic              h_gnt_q, c_gnt_q;
    logic              tie_to_c;
    logic              limit_hit;
    logic              sel_c, w_en_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    assign limit_hit = BURST_LIM && (burst_q == BURST_SAT);

    // Next-state: grant selection, burst limit and turnaround sequencing
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        last_owner_d = last_owner_q;
        preempt_d    = preempt_q;
`ifdef ARB_ROUND_ROBIN_EN
        tie_to_c     = (last_owner_q == OWN_H);
`else
        tie_to_c     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus_if.h_req && bus_if.c_req) state_d = tie_to_c ? S_GNT_C : S_GNT_H;
                else if (bus_if.h_req)            state_d = S_GNT_H;
                else if (bus_if.c_req)            state_d = S_GNT_C;
            end
            S_GNT_H: begin
                if (burst_q != BURST_SAT) burst_d = burst_q + CNT_W'(1);
                if (!bus_if.h_req || (limit_hit && bus_if.c_req)) begin
                    state_d      = S_TURN;
                    last_owner_d = OWN_H;
                    preempt_d    = bus_if.h_req;
                end
            end
            S_GNT_C: begin
                if (burst_q != BURST_SAT) burst_d = burst_q + CNT_W'(1);
                if (!bus_if.c_req || (limit_hit && bus_if.h_req)) begin
                    state_d      = S_TURN;
                    last_owner_d = OWN_C;
                    preempt_d    = bus_if.c_req;
                end
            end
            S_TURN: begin
                burst_d   = '0;
                preempt_d = 1'b0;
                // last_owner_q already names the master just released
                if (bus_if.h_req && bus_if.c_req) begin
                    if (preempt_q) state_d = (last_owner_q == OWN_H) ? S_GNT_C : S_GNT_H;
                    else           state_d = tie_to_c ? S_GNT_C : S_GNT_H;
                end else if (bus_if.h_req) begin
                    state_d = S_GNT_H;
                end else if (bus_if.c_req) begin
                    state_d = S_GNT_C;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Memory bus mux: only the owner's strobes reach the memory
    always_comb begin
        sel_c   = 1'b0;
        w_en_c  = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            S_GNT_H: begin
                sel_c   = bus_if.h_sel;
                w_en_c  = bus_if.h_sel & bus_if.h_w_en;
                addr_c  = bus_if.h_addr;
                wdata_c = bus_if.h_wdata;
            end
            S_GNT_C: begin
                sel_c   = bus_if.c_sel;
                w_en_c  = bus_if.c_sel & bus_if.c_w_en;
                addr_c  = bus_if.c_addr;
                wdata_c = bus_if.c_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            burst_q      <= '0;
            last_owner_q <= OWN_H;
            preempt_q    <= 1'b0;
            h_gnt_q      <= 1'b0;
            c_gnt_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            last_owner_q <= last_owner_d;
            preempt_q    <= preempt_d;
            h_gnt_q      <= (state_d == S_GNT_H);
            c_gnt_q      <= (state_d == S_GNT_C);
        end
    end

    assign data_bus           = w_en_c ? wdata_c : {DATA_W{1'bz}};
    assign bus_if.h_rdata     = data_bus;
    assign bus_if.c_rdata     = data_bus;
    assign bus_if.h_gnt       = h_gnt_q;
    assign bus_if.c_gnt       = c_gnt_q;
    assign bus_if.mem_sel     = sel_c;
    assign bus_if.mem_w_en    = w_en_c;
    assign bus_if.address_bus = addr_c;
    assign bus_if.owner       = state_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random request traffic, checked
// against an ownership model and a shadow copy of the scratch memory.
module tb_mem_bus_arbiter;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAXB   = 4;

    logic clk;
    logic rst;
    wire  [DATA_W-1:0] data_bus;

    logic              h_req, h_sel, h_w_en, c_req, c_sel, c_w_en;
    logic [ADDR_W-1:0] h_addr, c_addr;
    logic [DATA_W-1:0] h_wdata, c_wdata;
    logic              probe_en;

    int n_checks;
    int n_fail;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    assign bus_if.h_req   = h_req;
    assign bus_if.h_sel   = h_sel;
    assign bus_if.h_w_en  = h_w_en;
    assign bus_if.h_addr  = h_addr;
    assign bus_if.h_wdata = h_wdata;
    assign bus_if.c_req   = c_req;
    assign bus_if.c_sel   = c_sel;
    assign bus_if.c_w_en  = c_w_en;
    assign bus_if.c_addr  = c_addr;
    assign bus_if.c_wdata = c_wdata;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_if   (bus_if),
        .data_bus (data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratch memory: writes on the edge, read data driven onto data_bus for the following cycle
    logic [DATA_W-1:0] mem [256] = '{default: '0};
    logic [DATA_W-1:0] ref_mem [256];
    logic              rd_drv = 1'b0;
    logic [DATA_W-1:0] rd_q   = '0;

    always @(posedge clk) begin
        if (bus_if.mem_sel && bus_if.mem_w_en) mem[bus_if.address_bus] <= data_bus;
        rd_drv <= bus_if.mem_sel && !bus_if.mem_w_en;
        rd_q   <= mem[bus_if.address_bus];
    end

    assign data_bus = rd_drv   ? rd_q : {DATA_W{1'bz}};
    assign data_bus = probe_en ? '0   : {DATA_W{1'bz}};

    // Ownership model: 0 none, 1 host, 2 conv, 3 turnaround
    int m_own, m_run, m_last;
    bit m_pre;

    task automatic model_reset();
        m_own = 0; m_run = 0; m_last = 1; m_pre = 1'b0;
    endtask

    task automatic model_step(input bit hr, input bit cr);
        int  tie;
        bit  mine, other;
`ifdef ARB_ROUND_ROBIN_EN
        tie = 3 - m_last;
`else
        tie = 1;
`endif
        if (m_own == 0 || m_own == 3) begin
            if (hr && cr)  m_own = (m_own == 3 && m_pre) ? 3 - m_last : tie;
            else if (hr)   m_own = 1;
            else if (cr)   m_own = 2;
            else           m_own = 0;
            m_run = 0;
            m_pre = 1'b0;
        end else begin
            mine  = (m_own == 1) ? hr : cr;
            other = (m_own == 1) ? cr : hr;
            m_run = m_run + 1;
            if (!mine || (MAXB != 0 && m_run >= int'(MAXB) && other)) begin
                m_pre  = mine;
                m_last = m_own;
                m_own  = 3;
            end
        end
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle with the currently driven master inputs
    task automatic cycle();
        logic              e_sel, e_we, rd_pend;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data, rd_val;
        e_sel = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
        if (m_own == 1) begin
            e_sel = h_sel; e_we = h_sel & h_w_en; e_addr = h_addr; e_data = h_wdata;
        end else if (m_own == 2) begin
            e_sel = c_sel; e_we = c_sel & c_w_en; e_addr = c_addr; e_data = c_wdata;
        end
        probe_en = !e_we && !rd_drv;
        #1;
        check("mem_sel", 32'(bus_if.mem_sel), 32'(e_sel));
        check("mem_w_en", 32'(bus_if.mem_w_en), 32'(e_we));
        check("address_bus", 32'(bus_if.address_bus), 32'(e_addr));
        if (e_we)          check("write_data_on_bus", bus_if.h_rdata, e_data);
        else if (probe_en) check("bus_released", bus_if.h_rdata, '0);
        probe_en = 1'b0;
        if (e_we) ref_mem[e_addr] = e_data;
        rd_pend = e_sel && !e_we;
        rd_val  = ref_mem[e_addr];
        @(posedge clk);
        model_step(h_req, c_req);
        #1;
        check("h_gnt", 32'(bus_if.h_gnt), 32'(m_own == 1));
        check("c_gnt", 32'(bus_if.c_gnt), 32'(m_own == 2));
        check("owner", 32'(bus_if.owner), 32'(m_own));
        if (rd_pend) begin
            check("h_rdata", bus_if.h_rdata, rd_val);
            check("c_rdata", bus_if.c_rdata, rd_val);
        end
    endtask

    task automatic idle_inputs();
        h_sel = 1'b0; h_w_en = 1'b0; c_sel = 1'b0; c_w_en = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        model_reset();
        probe_en = 1'b0;
        rst = 1'b0;
        h_req = 1'b0; c_req = 1'b0; idle_inputs();
        h_addr = '0; c_addr = '0; h_wdata = '0; c_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_h_gnt", 32'(bus_if.h_gnt), 32'd0);
        check("rst_c_gnt", 32'(bus_if.c_gnt), 32'd0);
        check("rst_owner", 32'(bus_if.owner), 32'd0);
        check("rst_mem_sel", 32'(bus_if.mem_sel), 32'd0);
        check("rst_address_bus", 32'(bus_if.address_bus), 32'd0);
        rst = 1'b1;

        // Host alone loads addr 0..19
        h_req = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) begin
            h_sel = 1'b1; h_w_en = 1'b1; h_addr = 8'(i); h_wdata = 32'(i + 1);
            cycle();
        end
        idle_inputs(); h_req = 1'b0;
        repeat (2) cycle();

        // Conv alone: four reads, a gap while read data drains, then a write
        c_req = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            c_sel = 1'b1; c_w_en = 1'b0; c_addr = 8'(i);
            cycle();
        end
        idle_inputs();
        cycle();
        c_sel = 1'b1; c_w_en = 1'b1; c_addr = 8'd20; c_wdata = $urandom;
        cycle();
        idle_inputs(); c_req = 1'b0;
        repeat (2) cycle();

        // Simultaneous requests from idle; host releases then re-requests during turnaround
        h_req = 1'b1; c_req = 1'b1;
        repeat (2) cycle();
        h_req = 1'b0;
        cycle();
        h_req = 1'b1;
        repeat (2) cycle();
        h_req = 1'b0; c_req = 1'b0;
        repeat (3) cycle();

        // Burst-limit preemption; non-owner strobes aimed at addr 5 must be ignored
        h_req = 1'b1;
        cycle();
        c_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            h_sel = 1'b1; h_w_en = 1'b1;
            h_addr  = (m_own == 1) ? 8'(100 + i) : 8'd5;
            h_wdata = (m_own == 1) ? $urandom : 32'h0000_BEEF;
            c_sel = 1'b1; c_w_en = 1'b1;
            c_addr  = (m_own == 2) ? 8'(150 + i) : 8'd5;
            c_wdata = (m_own == 2) ? $urandom : 32'h0000_DEAD;
            cycle();
        end
        idle_inputs(); h_req = 1'b0; c_req = 1'b0;
        repeat (3) cycle();
        check("ignored_strobe_mem5", mem[5], ref_mem[5]);

        // Async reset in the middle of a conv write
        c_req = 1'b1;
        cycle();
        c_sel = 1'b1; c_w_en = 1'b1; c_addr = 8'd7; c_wdata = 32'h1234_5678;
        #1;
        check("pre_reset_mem_w_en", 32'(bus_if.mem_w_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_c_gnt", 32'(bus_if.c_gnt), 32'd0);
        check("async_h_gnt", 32'(bus_if.h_gnt), 32'd0);
        check("async_mem_sel", 32'(bus_if.mem_sel), 32'd0);
        check("async_mem_w_en", 32'(bus_if.mem_w_en), 32'd0);
        check("async_owner", 32'(bus_if.owner), 32'd0);
        probe_en = 1'b1;
        #1;
        check("async_bus_released", bus_if.h_rdata, '0);
        probe_en = 1'b0;
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cycle();
        c_req = 1'b0;
        repeat (2) cycle();

        // Random request and write traffic from both masters
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) h_req = ~h_req;
            if ($urandom_range(0, 7) == 0) c_req = ~c_req;
            h_sel = 1'($urandom_range(0, 1)); h_w_en = 1'b1;
            c_sel = 1'($urandom_range(0, 1)); c_w_en = 1'b1;
            h_addr = 8'($urandom); c_addr = 8'($urandom);
            h_wdata = $urandom; c_wdata = $urandom;
            cycle();
        end
        idle_inputs(); h_req = 1'b0; c_req = 1'b0;
        repeat (3) cycle();

        for (int i = 0; i < 256; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
